// File: rtl/cla_calc_top_if.sv
// Board-facing signal bundle for cla_calc_top: switches, button and LED outputs.
// The board (or bench) drives through master; the calculator uses slave.
interface cla_calc_top_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] sw;
  logic             cin_sw;
  logic             mode_sw;
  logic             btn;
  logic [WIDTH-1:0] led;
  logic             led_cout;
  logic             led_ovf;
  logic [1:0]       led_state;

  modport master (
    output sw, cin_sw, mode_sw, btn,
    input  led, led_cout, led_ovf, led_state
  );

  modport slave (
    input  sw, cin_sw, mode_sw, btn,
    output led, led_cout, led_ovf, led_state
  );
endinterface

// File: rtl/cla_calc_top.sv
// Clocked switch/LED calculator: debounced button steps through operand capture,
// a group carry-lookahead add/subtract and result display. Optional: CLA_ACCUM_EN.
module cla_calc_top #(
  parameter int WIDTH     = 5,
  parameter int GROUP     = 4,
  parameter int DB_CYCLES = 250000
) (
  input logic           clk,
  input logic           rst,
  cla_calc_top_if.slave io
);

  localparam int NGROUPS = (WIDTH + GROUP - 1) / GROUP;
  localparam int CW      = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             sync1, sync2, db_level, db_prev, press;
  logic [CW-1:0]    db_cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q, b_eff;
  logic             mode_q, cin_q, cout_q, ovf_q, c_eff;
  logic [WIDTH:0]   sum_full;
  logic             cap_a, cap_b, ld_res, chain;

  // Each carry is a flat sum-of-products from its group's carry-in; only the
  // group carry-ins are chained, so no bit-to-bit ripple exists.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             ci);
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c;
    logic             term, prod;
    int               lo;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < NGROUPS; grp++) begin
      lo = grp * GROUP;
      for (int j = lo; j < lo + GROUP; j++) begin
        if (j < WIDTH) begin
          term = c[lo];
          for (int m = lo; m <= j; m++) term = term & p[m];
          for (int k = lo; k <= j; k++) begin
            prod = g[k];
            for (int m = k + 1; m <= j; m++) prod = prod & p[m];
            term = term | prod;
          end
          c[j+1] = term;
        end
      end
    end
    return {c[WIDTH], p ^ c[WIDTH-1:0]};
  endfunction

  assign b_eff    = mode_q ? ~b_q : b_q;
  assign c_eff    = mode_q | cin_q;
  assign sum_full = cla_add(a_q, b_eff, c_eff);

  // NOTE: every clocked block uses <= so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= io.btn;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == CW'(DB_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = db_level & ~db_prev;

  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    ld_res  = 1'b0;
    chain   = 1'b0;
    case (state_q)
      S_A: if (press) begin
        cap_a   = 1'b1;
        state_d = S_B;
      end
      S_B: if (press) begin
        cap_b   = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        ld_res  = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: if (press) begin
`ifdef CLA_ACCUM_EN
        if (io.sw != '0) begin
          chain   = 1'b1;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
`else
        state_d = S_A;
`endif
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      io.led      <= '0;
      io.led_cout <= 1'b0;
      io.led_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_a)      a_q <= io.sw;
      else if (chain) a_q <= res_q;
      if (cap_b) begin
        b_q    <= io.sw;
        mode_q <= io.mode_sw;
        cin_q  <= io.cin_sw;
      end
      if (ld_res) begin
        res_q  <= sum_full[WIDTH-1:0];
        cout_q <= sum_full[WIDTH];
        ovf_q  <= (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      case (state_q)
        S_A, S_B: begin
          io.led      <= io.sw;
          io.led_cout <= 1'b0;
          io.led_ovf  <= 1'b0;
        end
        S_SHOW: begin
          io.led      <= res_q;
          io.led_cout <= cout_q;
          io.led_ovf  <= ovf_q;
        end
        default: ;  // S_CALC holds the previous display
      endcase
    end
  end

  assign io.led_state = state_q;

endmodule

// File: tb/tb_cla_calc_top.sv
// Directed bench for cla_calc_top at WIDTH=8, GROUP=4, DB_CYCLES=4; expected
// values are hand-computed. Define CLA_ACCUM_EN to exercise chained accumulation.
module tb_cla_calc_top;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_calc_top_if #(.WIDTH(8)) io ();

  cla_calc_top #(.WIDTH(8), .GROUP(4), .DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sync (2) + debounce (4) edges raise the level; the press acts on the 7th edge.
  task automatic press(input logic [1:0] cur, input logic [1:0] nxt, input string tag);
    io.btn = 1'b1;
    step(6);
    check({tag, " pre-press state"}, 8'(io.led_state), 8'(cur));
    step(1);
    check({tag, " post-press state"}, 8'(io.led_state), 8'(nxt));
  endtask

  task automatic release_btn();
    io.btn = 1'b0;
    step(12);
  endtask

  // Starts in S_A; finishes in S_SHOW with the result displayed.
  task automatic calc(input logic [7:0] a, input logic [7:0] b, input logic mode,
                      input logic cin, input logic [7:0] exp_led, input logic exp_cout,
                      input logic exp_ovf, input string tag);
    io.sw = a;
    press(2'b00, 2'b01, {tag, " A"});
    release_btn();
    io.sw      = b;
    io.mode_sw = mode;
    io.cin_sw  = cin;
    press(2'b01, 2'b10, {tag, " B"});
    step(1);
    check({tag, " show state"}, 8'(io.led_state), 8'h03);
    check({tag, " led held in calc"}, io.led, b);
    step(1);
    check({tag, " led"}, io.led, exp_led);
    check({tag, " cout"}, 8'(io.led_cout), 8'(exp_cout));
    check({tag, " ovf"}, 8'(io.led_ovf), 8'(exp_ovf));
    release_btn();
    check({tag, " held state"}, 8'(io.led_state), 8'h03);
    check({tag, " held led"}, io.led, exp_led);
  endtask

  task automatic back_to_a(input string tag);
    io.sw = 8'h00;
    press(2'b11, 2'b00, tag);
    release_btn();
  endtask

  initial begin
    rst        = 1'b1;
    io.btn     = 1'b0;
    io.sw      = 8'h3C;
    io.mode_sw = 1'b0;
    io.cin_sw  = 1'b0;
    step(3);
    check("reset state", 8'(io.led_state), 8'h00);
    check("reset led", io.led, 8'h00);
    check("reset cout", 8'(io.led_cout), 8'h00);
    check("reset ovf", 8'(io.led_ovf), 8'h00);
    rst = 1'b0;
    step(1);
    check("idle echo", io.led, 8'h3C);

    calc(8'd100, 8'd55, 1'b0, 1'b0, 8'h9B, 1'b0, 1'b1, "add");
    back_to_a("ret1");
    calc(8'd20, 8'd30, 1'b1, 1'b1, 8'hF6, 1'b0, 1'b0, "sub neg");
    back_to_a("ret2");
    calc(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "wrap");
    back_to_a("ret3");
    calc(8'd30, 8'd20, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, "sub pos");

`ifdef CLA_ACCUM_EN
    io.sw = 8'h05;
    press(2'b11, 2'b01, "accum chain");
    release_btn();
    io.sw      = 8'h03;
    io.mode_sw = 1'b0;
    io.cin_sw  = 1'b0;
    press(2'b01, 2'b10, "accum B");
    step(2);
    check("accum led", io.led, 8'h0D);
    check("accum cout", 8'(io.led_cout), 8'h00);
    release_btn();
    back_to_a("accum zero");
`else
    io.sw = 8'h05;
    press(2'b11, 2'b00, "no accum");
    release_btn();
    check("no accum echo", io.led, 8'h05);
`endif

    io.sw = 8'h11;
    for (int i = 0; i < 10; i++) begin
      io.btn = ~io.btn;
      step(2);
    end
    check("bounce no advance", 8'(io.led_state), 8'h00);
    io.btn = 1'b1;
    step(10);
    check("bounce one advance", 8'(io.led_state), 8'h01);
    release_btn();
    check("bounce release", 8'(io.led_state), 8'h01);
    io.btn = 1'b1;
    step(3);
    io.btn = 1'b0;
    step(12);
    check("glitch ignored", 8'(io.led_state), 8'h01);

    io.sw      = 8'hF0;
    io.mode_sw = 1'b0;
    io.cin_sw  = 1'b0;
    press(2'b01, 2'b10, "rst seq B");
    step(2);
    check("rst seq led", io.led, 8'h01);
    check("rst seq cout", 8'(io.led_cout), 8'h01);
    release_btn();
    rst = 1'b1;
    step(1);
    check("mid rst state", 8'(io.led_state), 8'h00);
    check("mid rst led", io.led, 8'h00);
    check("mid rst cout", 8'(io.led_cout), 8'h00);
    rst = 1'b0;
    step(1);
    check("post rst echo", io.led, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
